// File: rtl/msk_pkg.sv
`default_nettype none
// ============================================================================
// Package : msk_pkg
// Shared defaults and types for the MSK receive front end (CIC decimator).
// Revision: 1.0 - initial release
// ============================================================================
package msk_pkg;

  // Default decimation ratio and stage count: 800 MHz -> 40 MHz, 3rd order.
  localparam int CIC_R = 20;
  localparam int CIC_N = 3;

  // Baseband sample pair as exchanged between front-end stages.
  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq16_t;

  // Internal CIC width: input width plus the bit growth of gain R**N.
  function automatic int cic_acc_width(input int in_w, input int r, input int n);
    return in_w + $clog2(r ** n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_channel.sv
`default_nettype none
// ============================================================================
// Module  : cic_channel
// One rail of a CIC decimator: registered integrator chain running at the
// input rate, and a comb chain (M=1) that advances once per decimation strobe.
// Revision: 1.0 - initial release
// ============================================================================
module cic_channel
  import msk_pkg::*;
#(
  parameter int R     = CIC_R,
  parameter int N     = CIC_N,
  parameter int IN_W  = 16,
  parameter int ACC_W = cic_acc_width(IN_W, R, N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    strobe,
  input  logic signed [IN_W-1:0]  x,
  output logic signed [ACC_W-1:0] y
);

  logic signed [ACC_W-1:0] integ [N];
  logic signed [ACC_W-1:0] x_ext;

  assign x_ext = {{(ACC_W-IN_W){x[IN_W-1]}}, x};

  // Integrator chain: each stage adds the previous stage's registered value; wrap is intended.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else if (in_valid) begin
      integ[0] <= integ[0] + x_ext;
      for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Comb chain: stage k differences its input against the value it saw on the previous strobe.
  for (genvar k = 0; k < N; k++) begin : g_comb
    logic signed [ACC_W-1:0] din;
    logic signed [ACC_W-1:0] dout;
    logic signed [ACC_W-1:0] dly;

    if (k == 0) begin : g_first
      assign din = integ[N-1];
    end else begin : g_next
      assign din = g_comb[k-1].dout;
    end

    assign dout = din - dly;

    // Comb delay register, advanced only at the decimated rate.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)       dly <= '0;
      else if (strobe) dly <= din;
    end
  end

  assign y = g_comb[N-1].dout;

endmodule
`default_nettype wire

// File: rtl/iq_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module  : iq_cic_decimator
// Decimating CIC filter for the baseband I/Q pair. Shared decimation counter
// and strobe pipeline, per-rail cic_channel, output register with valid/ready
// handshake and a sticky overrun flag. Input is never stalled.
// Revision: 1.0 - initial release
// ============================================================================
module iq_cic_decimator
  import msk_pkg::*;
#(
  parameter int R     = CIC_R,
  parameter int N     = CIC_N,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  i_in,
  input  logic signed [IN_W-1:0]  q_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    overrun,
  input  logic                    clr_ovr
);

  localparam int ACC_W = cic_acc_width(IN_W, R, N);
  localparam int SHIFT = ACC_W - OUT_W;
  localparam int CNT_W = $clog2(R);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

  logic [CNT_W-1:0]        cnt;
  logic                    strobe;
  logic                    strobe_d;
  logic signed [ACC_W-1:0] i_comb;
  logic signed [ACC_W-1:0] q_comb;

  // The R-th accepted sample of a group closes the group.
  assign strobe = in_valid && (cnt == CNT_LAST);

  // Decimation counter: advances on accepted samples only, wraps after R-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (in_valid) cnt <= strobe ? '0 : cnt + CNT_W'(1);
  end

  // One-cycle delay so the combs see the integrator value that includes the R-th sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) strobe_d <= 1'b0;
    else       strobe_d <= strobe;
  end

  cic_channel #(
    .R    (R),
    .N    (N),
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_chan_i (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .strobe  (strobe_d),
    .x       (i_in),
    .y       (i_comb)
  );

  cic_channel #(
    .R    (R),
    .N    (N),
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_chan_q (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .strobe  (strobe_d),
    .x       (q_in),
    .y       (q_comb)
  );

  // Output register: floor-scaled comb result, overwritten on every new result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_out <= '0;
      q_out <= '0;
    end else if (strobe_d) begin
      i_out <= OUT_W'(i_comb >>> SHIFT);
      q_out <= OUT_W'(q_comb >>> SHIFT);
    end
  end

  // Handshake and sticky overrun; a new result wins over both accept and clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (strobe_d)                    out_valid <= 1'b1;
      else if (out_valid && out_ready) out_valid <= 1'b0;

      if (strobe_d && out_valid && !out_ready) overrun <= 1'b1;
      else if (clr_ovr)                        overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iq_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module  : tb_iq_cic_decimator
// Self-checking bench for iq_cic_decimator. Reference: the CIC as an FIR whose
// taps are R-long boxcars convolved N times, evaluated on the history of
// accepted samples and decimated by R, with a cycle-level handshake model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iq_cic_decimator;

  localparam int R     = 20;
  localparam int N     = 3;
  localparam int SHIFT = 13;
  localparam int HLEN  = N * (R - 1) + 1;

  logic clk = 1'b0;
  logic reset, in_valid, out_ready, clr_ovr;
  logic out_valid, overrun;
  logic signed [15:0] i_in, q_in, i_out, q_out;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int   h [HLEN];
  int   hist_i[$];
  int   hist_q[$];
  logic exp_v, exp_ovr;
  int   exp_i, exp_q;
  bit   pend;
  int   pend_i, pend_q, pend_step;
  int   step_no;
  bit   last_load;
  int   load_steps[$];
  int   load_vals[$];

  always #5 clk = ~clk;

  iq_cic_decimator dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .i_in     (i_in),
    .q_in     (q_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .i_out    (i_out),
    .q_out    (q_out),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  // FIR form of the filter on the latest accepted sample; the registered
  // integrator chain delays the response by N-1 samples.
  function automatic int model_out(input bit use_q);
    longint acc;
    int     n;
    acc = 0;
    n   = hist_i.size() - 1;
    for (int j = 0; j < HLEN; j++) begin
      int idx;
      idx = n - (N - 1) - j;
      if (idx >= 0)
        acc += longint'(h[j]) * longint'(use_q ? hist_q[idx] : hist_i[idx]);
    end
    return int'(acc >>> SHIFT);
  endfunction

  task automatic step(input logic v, input int xi, input int xq, input logic rdy, input logic clr);
    @(negedge clk);
    in_valid  = v;
    i_in      = 16'(xi);
    q_in      = 16'(xq);
    out_ready = rdy;
    clr_ovr   = clr;
    @(posedge clk);
    #1;
    step_no++;
    last_load = pend && (pend_step == step_no);
    if (last_load) begin
      if (exp_v && !rdy) exp_ovr = 1'b1;
      else if (clr)      exp_ovr = 1'b0;
      exp_v = 1'b1;
      exp_i = pend_i;
      exp_q = pend_q;
      pend  = 1'b0;
      load_steps.push_back(step_no);
      load_vals.push_back(pend_i);
    end else begin
      if (exp_v && rdy) exp_v = 1'b0;
      if (clr)          exp_ovr = 1'b0;
    end
    if (v) begin
      hist_i.push_back(int'($signed(16'(xi))));
      hist_q.push_back(int'($signed(16'(xq))));
      if (hist_i.size() % R == 0) begin
        pend      = 1'b1;
        pend_step = step_no + 1;
        pend_i    = model_out(1'b0);
        pend_q    = model_out(1'b1);
      end
    end
    chk("out_valid", out_valid, exp_v);
    chk("overrun", overrun, exp_ovr);
    chk("i_out", i_out, exp_i);
    chk("q_out", q_out, exp_q);
  endtask

  // Reset is raised between clock edges so the asynchronous clear is observable.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovr   = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_i_out", i_out, 0);
    chk("rst_q_out", q_out, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    hist_i.delete();
    hist_q.delete();
    load_steps.delete();
    load_vals.delete();
    exp_v   = 1'b0;
    exp_ovr = 1'b0;
    exp_i   = 0;
    exp_q   = 0;
    pend    = 1'b0;
    step_no = 0;
  endtask

  initial begin
    int tmp [HLEN];
    int len;
    int s;
    bit hit;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
    i_in = '0; q_in = '0;

    // taps: R-long boxcar convolved with itself N times
    for (int j = 0; j < HLEN; j++) h[j] = 0;
    h[0] = 1;
    len  = 1;
    for (int st = 0; st < N; st++) begin
      for (int j = 0; j < HLEN; j++) begin
        tmp[j] = 0;
        for (int m = 0; m < R; m++) if (j - m >= 0) tmp[j] += h[j - m];
      end
      len += R - 1;
      for (int j = 0; j < HLEN; j++) h[j] = tmp[j];
    end

    do_reset();

    // DC with continuous valid and ready
    for (int k = 0; k < 200; k++) step(1'b1, 1000, -1000, 1'b1, 1'b0);
    chk("dc_i", i_out, 976);
    chk("dc_q", q_out, -977);

    // single impulse; latency and output rate
    do_reset();
    step(1'b1, 8192, 0, 1'b1, 1'b0);
    for (int k = 0; k < 79; k++) step(1'b1, 0, 0, 1'b1, 1'b0);
    chk("latency", load_steps[0], 21);
    chk("period", load_steps[1] - load_steps[0], R);
    chk("impulse_count", load_vals.size(), 3);
    // an impulse excites one polyphase branch, whose taps sum to R**(N-1)=400;
    // 8192 = 2**SHIFT so each output is the tap value exactly
    if (load_vals.size() >= 3) begin
      s = load_vals[0] + load_vals[1] + load_vals[2];
      chk("impulse_sum", s, 400);
    end

    // 50% input duty
    do_reset();
    for (int k = 0; k < 400; k++) step(k % 2 == 0, 1000, -1000, 1'b1, 1'b0);
    chk("half_rate_period", load_steps[1] - load_steps[0], 2 * R);
    chk("half_rate_i", i_out, 976);
    chk("half_rate_q", q_out, -977);

    // overrun set, clear, and set winning over clear
    do_reset();
    for (int k = 0; k < 40; k++) step(1'b1, 1000, -1000, 1'b1, 1'b0);
    for (int k = 0; k < 45; k++) step(1'b1, 1000, -1000, 1'b0, 1'b0);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_hold_valid", out_valid, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    chk("ovr_clr", overrun, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 25 && !hit; k++) begin
      step(1'b1, 1000, -1000, 1'b0, 1'b1);
      hit = last_load;
    end
    chk("ovr_load_seen", hit, 1'b1);
    chk("ovr_set_beats_clr", overrun, 1'b1);

    // full scale: no saturation in the wrapping accumulators
    do_reset();
    for (int k = 0; k < 10000; k++) step(1'b1, 32767, -32768, 1'b1, 1'b0);
    chk("fullscale_i", i_out, 31999);
    chk("fullscale_q", q_out, -32000);

    // reset mid-group, then the counter restarts from zero
    for (int k = 0; k < 7; k++) step(1'b1, 32767, -32768, 1'b1, 1'b0);
    do_reset();
    for (int k = 0; k < 25; k++) step(1'b1, 1000, -1000, 1'b1, 1'b0);
    chk("restart_latency", load_steps[0], 21);

    // random traffic
    do_reset();
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
